// File: rtl/msg_comm_pkg.sv
// Shared definitions for the message TX/RX path: byte width, default frame
// length width, inter-frame gap and progress timeout, and the TX arbiter
// state encoding.
package msg_comm_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned LEN_W_DEF          = 16;
  localparam int unsigned GAP_CYCLES_DEF     = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 65535;
  localparam int unsigned ID_W               = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_START,
    ST_XFER,
    ST_WAIT_DONE,
    ST_GAP
  } msg_tx_state_e;

endpackage

// File: rtl/msg_rr_arbiter.sv
// Combinational round-robin picker.
//   req  : request vector
//   ptr  : highest-priority index for this pick
//   gnt  : one-hot grant (all zero when nothing requested)
//   idx  : binary index of the granted bit
//   any  : at least one request present
module msg_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Two passes replace a modular scan: first the lowest request at or above
  // ptr, otherwise the lowest request overall (which must lie below ptr).
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any && req[k] && (k >= 32'(ptr))) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/msg_tx_arbiter.sv
// Shares the message TX serializer between NUM_REQ requesters, one frame at
// a time in round-robin order. Per frame: announce the length, pace bytes
// from the granted source, wait for the serializer's frame-done, then hold
// off for GAP_CYCLES. A frame that makes no progress for TIMEOUT_CYCLES is
// abandoned with an error pulse.
//   clk, rst        : clock, asynchronous active-high reset
//   req_i/req_len_i : per-requester frame request and byte count
//   gnt_o           : registered one-hot grant
//   src_vld_i/src_data_i/src_rdy_o : per-requester byte handshake
//   tx_start_o/tx_len_o            : frame start pulse and length
//   tx_en_o/tx_data_o/tx_rdy_i     : byte strobe towards the serializer
//   tx_done_i       : serializer finished the frame
//   done_o          : completion pulse to the served requester
//   busy_o          : arbiter not idle
//   err_timeout_o/err_id_o         : abort pulse and aborted requester
module msg_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned LEN_W          = msg_comm_pkg::LEN_W_DEF,
  parameter int unsigned GAP_CYCLES     = msg_comm_pkg::GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = msg_comm_pkg::TIMEOUT_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  input  logic [NUM_REQ-1:0]         src_vld_i,
  input  logic [NUM_REQ*8-1:0]       src_data_i,
  output logic [NUM_REQ-1:0]         src_rdy_o,
  output logic                       tx_start_o,
  output logic [LEN_W-1:0]           tx_len_o,
  output logic                       tx_en_o,
  output logic [7:0]                 tx_data_o,
  input  logic                       tx_rdy_i,
  input  logic                       tx_done_i,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       busy_o,
  output logic                       err_timeout_o,
  output logic [2:0]                 err_id_o
);

  import msg_comm_pkg::*;

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  msg_tx_state_e state_q, state_d;

  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   tx_len_q;
  logic               tx_en_q;
  logic [7:0]         tx_data_q;
  logic [NUM_REQ-1:0] done_q;
  logic               err_q;
  logic [ID_W-1:0]    err_id_q;
  logic [31:0]        to_cnt;
  logic [31:0]        gap_cnt;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [LEN_W-1:0]   pick_len;

  logic [LEN_W-1:0]   len_arr  [NUM_REQ];
  logic [7:0]         data_arr [NUM_REQ];

  logic               fire;
  logic               to_hit;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      len_arr[i]  = req_len_i[i*LEN_W +: LEN_W];
      data_arr[i] = src_data_i[i*8 +: 8];
    end
  end

  msg_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_len = len_arr[pick_idx];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (|req_i) state_d = ST_ARB;
      ST_ARB: begin
        if (!pick_any)            state_d = ST_IDLE;
        else if (pick_len == '0)  state_d = ST_GAP;
        else                      state_d = ST_START;
      end
      ST_START:     state_d = ST_XFER;
      ST_XFER: begin
        if (to_hit)                                  state_d = ST_GAP;
        else if (fire && (rem_q == LEN_W'(1)))       state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (tx_done_i || to_hit) state_d = ST_GAP;
      ST_GAP:       if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output / handshake logic
  always_comb begin
    src_rdy_o  = '0;
    fire       = 1'b0;
    to_hit     = 1'b0;
    tx_start_o = (state_q == ST_START);
    busy_o     = (state_q != ST_IDLE);
    tx_len_o   = (state_q == ST_START) ? rem_q : tx_len_q;
    if ((state_q == ST_XFER) && tx_rdy_i && (rem_q != '0)) begin
      src_rdy_o[gidx_q] = 1'b1;
    end
    fire = (state_q == ST_XFER) && src_vld_i[gidx_q] && src_rdy_o[gidx_q];
    if (to_cnt == TO_LAST) begin
      to_hit = ((state_q == ST_XFER) && !fire) ||
               ((state_q == ST_WAIT_DONE) && !tx_done_i);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      tx_len_q  <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
    end else begin
      tx_en_q <= fire;
      done_q  <= '0;
      err_q   <= 1'b0;
      if (fire) tx_data_q <= data_arr[gidx_q];

      case (state_q)
        ST_ARB: begin
          if (pick_any) begin
            gidx_q <= pick_idx;
            rem_q  <= pick_len;
            if (32'(pick_idx) == NUM_REQ - 1) ptr_q <= '0;
            else                              ptr_q <= pick_idx + 1'b1;
            if (pick_len == '0) done_q <= pick_gnt;
            else                gnt_q  <= pick_gnt;
          end
        end
        ST_START: tx_len_q <= rem_q;
        ST_XFER: begin
          if (fire) rem_q <= rem_q - 1'b1;
          if (to_hit) begin
            err_q    <= 1'b1;
            err_id_q <= ID_W'(gidx_q);
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done_i) begin
            done_q <= gnt_q;
          end else if (to_hit) begin
            err_q    <= 1'b1;
            err_id_q <= ID_W'(gidx_q);
          end
        end
        default: ;
      endcase

      if (state_d == ST_GAP) gnt_q <= '0;

      if (fire || (state_d != state_q))                        to_cnt <= '0;
      else if ((state_q == ST_XFER) || (state_q == ST_WAIT_DONE)) to_cnt <= to_cnt + 1'b1;

      if ((state_q == ST_GAP) && (state_d == ST_GAP)) gap_cnt <= gap_cnt + 1'b1;
      else                                            gap_cnt <= '0;
    end
  end

  assign gnt_o         = gnt_q;
  assign tx_en_o       = tx_en_q;
  assign tx_data_o     = tx_data_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_q;
  assign err_id_o      = err_id_q;

endmodule
